// File: rtl/quant_pkg.sv
// Shared constants for the fp32 multiply / requantize path: rounding modes,
// fp32 field layout, and the round-increment decision used by stage 2.
package quant_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RDN = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RTZ = 2'b11;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_BIAS  = 127;

  // True when the truncated magnitude must be bumped by one LSB.
  function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                     input logic lsb, input logic guard,
                                     input logic sticky);
    case (rm)
      RM_RNE:  return guard & (sticky | lsb);
      RM_RDN:  return sign & (guard | sticky);
      RM_RUP:  return ~sign & (guard | sticky);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp32_to_int_round.sv
// One-lane fp32 -> signed OUT_W integer: input capture, decode/align,
// then round, zero-point offset and saturate. Three register stages.
module fp32_to_int_round
  import quant_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ena,
  input  logic [31:0]      a,
  input  logic [1:0]       rm,
  input  logic [OUT_W-1:0] zp,
  output logic             y_valid,
  output logic [OUT_W-1:0] y,
  output logic             y_sat
);

  localparam int MW = OUT_W + 2;
  localparam int SW = OUT_W + 3;
  localparam logic signed [SW-1:0] YMAX = {{4{1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] YMIN = {{4{1'b1}}, {(OUT_W-1){1'b0}}};

  logic             v0;
  logic [31:0]      a0;
  logic [1:0]       rm0;
  logic [OUT_W-1:0] zp0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v0  <= 1'b0;
      a0  <= '0;
      rm0 <= '0;
      zp0 <= '0;
    end else begin
      v0 <= ena;
      if (ena) begin
        a0  <= a;
        rm0 <= rm;
        zp0 <= zp;
      end
    end
  end

  logic                  sign_d, g_d, s_d, big_d, nan_d;
  logic [FP32_EXP_W-1:0] exp_d;
  logic [FP32_MAN_W-1:0] frac_d;
  logic [FP32_MAN_W:0]   mant_d, mask_d;
  logic signed [9:0]     e_d;
  logic [4:0]            sh_d, gpos_d;
  logic [MW-1:0]         mag_d;

  always_comb begin
    sign_d = a0[31];
    exp_d  = a0[30:23];
    frac_d = a0[22:0];
    mant_d = {exp_d != '0, frac_d};
    e_d    = $signed({2'b00, exp_d}) - $signed(10'(FP32_BIAS));
    nan_d  = (exp_d == '1) && (frac_d != '0);
    big_d  = (exp_d == '1) || (e_d >= $signed(10'(OUT_W + 1)));
    sh_d   = '0;
    gpos_d = '0;
    mask_d = '0;
    mag_d  = '0;
    g_d    = 1'b0;
    s_d    = 1'b0;
    if (big_d) begin
      s_d = 1'b0;
    end else if (e_d < -10'sd1) begin
      // Below 0.5 (including denormals): only the sticky bit survives.
      s_d = |mant_d;
    end else begin
      sh_d   = 5'(10'sd23 - e_d);
      gpos_d = sh_d - 5'd1;
      mask_d = (24'd1 << gpos_d) - 24'd1;
      mag_d  = MW'(mant_d >> sh_d);
      g_d    = mant_d[gpos_d];
      s_d    = |(mant_d & mask_d);
    end
  end

  logic             v1, sign1, g1, s1, big1, nan1;
  logic [MW-1:0]    mag1;
  logic [1:0]       rm1;
  logic [OUT_W-1:0] zp1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      g1    <= 1'b0;
      s1    <= 1'b0;
      big1  <= 1'b0;
      nan1  <= 1'b0;
      mag1  <= '0;
      rm1   <= '0;
      zp1   <= '0;
    end else begin
      v1 <= v0;
      if (v0) begin
        sign1 <= sign_d;
        g1    <= g_d;
        s1    <= s_d;
        big1  <= big_d;
        nan1  <= nan_d;
        mag1  <= mag_d;
        rm1   <= rm0;
        zp1   <= zp0;
      end
    end
  end

  logic                 inc_c, sat_c;
  logic [SW-1:0]        rmag_c;
  logic signed [SW-1:0] sval_c, sum_c;
  logic [OUT_W-1:0]     y_c;

  always_comb begin
    inc_c  = round_inc(rm1, sign1, mag1[0], g1, s1);
    rmag_c = {1'b0, mag1} + {{MW{1'b0}}, inc_c};
    sval_c = sign1 ? -$signed(rmag_c) : $signed(rmag_c);
    sum_c  = sval_c + $signed({{3{zp1[OUT_W-1]}}, zp1});
    y_c    = sum_c[OUT_W-1:0];
    sat_c  = 1'b0;
    if (nan1) begin
      y_c   = zp1;
      sat_c = 1'b1;
    end else if (big1) begin
      y_c   = sign1 ? YMIN[OUT_W-1:0] : YMAX[OUT_W-1:0];
      sat_c = 1'b1;
    end else if (sum_c > YMAX) begin
      y_c   = YMAX[OUT_W-1:0];
      sat_c = 1'b1;
    end else if (sum_c < YMIN) begin
      y_c   = YMIN[OUT_W-1:0];
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_valid <= 1'b0;
      y       <= '0;
      y_sat   <= 1'b0;
    end else begin
      y_valid <= v1;
      if (v1) begin
        y     <= y_c;
        y_sat <= sat_c;
      end
    end
  end

endmodule

// File: rtl/fp32_quant_pack.sv
// Requantizes fp32 lanes to OUT_W-bit integers and packs PACK lanes per word,
// with clr-driven partial-word flush and a sticky clamp counter.
module fp32_quant_pack
  import quant_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int PACK  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ena,
  input  logic [31:0]           a,
  input  logic [1:0]            rm,
  input  logic [OUT_W-1:0]      zp,
  input  logic                  clr,
  output logic [PACK*OUT_W-1:0] q,
  output logic                  q_valid,
  output logic [15:0]           sat_cnt
);

  localparam int IW = (PACK > 1) ? $clog2(PACK) : 1;

  logic             y_valid, y_sat;
  logic [OUT_W-1:0] y;

  fp32_to_int_round #(.OUT_W(OUT_W)) u_conv (
    .clk     (clk),
    .rstn    (rstn),
    .ena     (ena),
    .a       (a),
    .rm      (rm),
    .zp      (zp),
    .y_valid (y_valid),
    .y       (y),
    .y_sat   (y_sat)
  );

  // clr travels the same three stages as the lane sampled with it.
  logic [2:0]            clr_pipe;
  logic [IW-1:0]         idx, idx_n;
  logic [PACK*OUT_W-1:0] slots, slots_n, word_n;
  logic                  emit_n;

  always_comb begin
    slots_n = slots;
    idx_n   = idx;
    word_n  = slots;
    emit_n  = 1'b0;
    if (y_valid) begin
      slots_n[idx*OUT_W +: OUT_W] = y;
      if (idx == IW'(PACK - 1)) begin
        emit_n  = 1'b1;
        word_n  = slots_n;
        slots_n = '0;
        idx_n   = '0;
      end else begin
        idx_n = idx + IW'(1);
      end
    end
    if (clr_pipe[2] && !emit_n && idx_n != '0) begin
      emit_n  = 1'b1;
      word_n  = slots_n;
      slots_n = '0;
      idx_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_pipe <= '0;
      idx      <= '0;
      slots    <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      sat_cnt  <= '0;
    end else begin
      clr_pipe <= {clr_pipe[1:0], clr};
      idx      <= idx_n;
      slots    <= slots_n;
      q_valid  <= emit_n;
      if (emit_n) q <= word_n;
      if (y_valid && y_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fp32_quant_pack.sv
// Bench for fp32_quant_pack: constant vector table, directed word sequences,
// and randomized lanes scored against a real-arithmetic reference.
module tb_fp32_quant_pack;

  localparam int OUT_W = 8;
  localparam int PACK  = 4;

  logic        clk = 1'b0, rstn = 1'b0, ena = 1'b0, clr = 1'b0;
  logic [31:0] a = '0;
  logic [1:0]  rm = '0;
  logic [7:0]  zp = '0;
  logic [31:0] q;
  logic        q_valid;
  logic [15:0] sat_cnt;

  fp32_quant_pack #(.OUT_W(OUT_W), .PACK(PACK)) dut (
    .clk(clk), .rstn(rstn), .ena(ena), .a(a), .rm(rm), .zp(zp), .clr(clr),
    .q(q), .q_valid(q_valid), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, exp_sat = 0;
  logic [31:0] got_q[$], exp_q[$];
  int          got_c[$], exp_c[$];
  logic [7:0]  part[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (q_valid) begin
      got_q.push_back(q);
      got_c.push_back(cyc);
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, expv);
    end
  endtask

  // Reference conversion from the numeric definition, using real arithmetic.
  function automatic void ref_lane(input logic [31:0] av, input logic [1:0] r,
                                   input logic [7:0] z, output logic [7:0] yv,
                                   output bit sat);
    int ex, e, ri, s;
    longint mant;
    real v, fl, fr;
    ex  = int'(av[30:23]);
    sat = 1'b1;
    if (ex == 255 && av[22:0] != 0) begin
      yv = z;
      return;
    end
    if (ex == 255 || ex - 127 >= OUT_W + 1) begin
      yv = av[31] ? 8'h80 : 8'h7F;
      return;
    end
    mant = (ex == 0) ? longint'(av[22:0]) : longint'(av[22:0]) + 64'd8388608;
    e    = (ex == 0) ? -126 : ex - 127;
    v    = real'(mant);
    for (int k = 0; k < 23 - e; k++) v = v / 2.0;
    if (av[31]) v = -v;
    fl = $floor(v);
    ri = $rtoi(fl);
    case (r)
      2'd0: begin
        fr = v - fl;
        if (fr > 0.5 || (fr == 0.5 && ri % 2 != 0)) ri++;
      end
      2'd1: ri = $rtoi(fl);
      2'd2: ri = $rtoi($ceil(v));
      default: ri = $rtoi(v);
    endcase
    s   = ri + int'($signed(z));
    sat = 1'b0;
    if (s > 127) begin s = 127; sat = 1'b1; end
    else if (s < -128) begin s = -128; sat = 1'b1; end
    yv = 8'(s);
  endfunction

  task automatic emit_model();
    logic [31:0] w;
    w = '0;
    foreach (part[i]) w[i*8 +: 8] = part[i];
    exp_q.push_back(w);
    exp_c.push_back(cyc + 4);
    part.delete();
  endtask

  task automatic drive(input bit en, input logic [31:0] av, input logic [1:0] r,
                       input logic [7:0] z, input bit c, input logic [7:0] ye, input bit se);
    @(negedge clk);
    ena = en; a = av; rm = r; zp = z; clr = c;
    if (en) begin
      part.push_back(ye);
      if (se && exp_sat < 65535) exp_sat++;
    end
    if (part.size() == PACK || (c && part.size() > 0)) emit_model();
  endtask

  task automatic lane_k(input logic [31:0] av, input logic [1:0] r, input logic [7:0] z,
                        input bit c, input logic [7:0] ye, input bit se);
    drive(1'b1, av, r, z, c, ye, se);
  endtask

  task automatic lane_r(input logic [31:0] av, input logic [1:0] r, input logic [7:0] z, input bit c);
    logic [7:0] ye;
    bit se;
    ref_lane(av, r, z, ye, se);
    drive(1'b1, av, r, z, c, ye, se);
  endtask

  task automatic idle(input bit c);
    drive(1'b0, 32'h0, 2'd0, 8'h00, c, 8'h00, 1'b0);
  endtask

  task automatic drain(input string nm);
    repeat (6) idle(1'b0);
    while (exp_q.size() > 0 || got_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        check({nm, " extra q_valid"}, got_q.pop_front(), 32'hxxxx_xxxx);
        void'(got_c.pop_front());
      end else if (got_q.size() == 0) begin
        check({nm, " missing q_valid"}, 32'h0, exp_q.pop_front());
        void'(exp_c.pop_front());
      end else begin
        check({nm, " q"}, got_q.pop_front(), exp_q.pop_front());
        check({nm, " q_valid cycle"}, 32'(got_c.pop_front()), 32'(exp_c.pop_front()));
      end
    end
    check({nm, " sat_cnt"}, {16'h0, sat_cnt}, 32'(exp_sat));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [1:0]  rm;
    logic [7:0]  zp;
    logic [7:0]  y;
    bit          sat;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{32'h40C00000, 2'd0, 8'h00, 8'h06, 1'b0});
    tbl.push_back('{32'hC0700000, 2'd0, 8'h00, 8'hFC, 1'b0});
    tbl.push_back('{32'hC0700000, 2'd3, 8'h00, 8'hFD, 1'b0});
    tbl.push_back('{32'h40200000, 2'd0, 8'h00, 8'h02, 1'b0});
    tbl.push_back('{32'h40600000, 2'd0, 8'h00, 8'h04, 1'b0});
    tbl.push_back('{32'h40200000, 2'd2, 8'h00, 8'h03, 1'b0});
    tbl.push_back('{32'hC0200000, 2'd1, 8'h00, 8'hFD, 1'b0});
    tbl.push_back('{32'hC0200000, 2'd2, 8'h00, 8'hFE, 1'b0});
    tbl.push_back('{32'h43960000, 2'd0, 8'h00, 8'h7F, 1'b1});
    tbl.push_back('{32'hFF800000, 2'd0, 8'h00, 8'h80, 1'b1});
    tbl.push_back('{32'h7FC12345, 2'd0, 8'h05, 8'h05, 1'b1});
    tbl.push_back('{32'h437F0000, 2'd0, 8'h80, 8'h7F, 1'b0});
    tbl.push_back('{32'h43800000, 2'd0, 8'h80, 8'h7F, 1'b1});
    tbl.push_back('{32'h3F000000, 2'd0, 8'h80, 8'h80, 1'b0});
    tbl.push_back('{32'h80000001, 2'd1, 8'h00, 8'hFF, 1'b0});
    tbl.push_back('{32'h00000001, 2'd2, 8'h00, 8'h01, 1'b0});
    tbl.push_back('{32'h00000001, 2'd0, 8'h00, 8'h00, 1'b0});
    tbl.push_back('{32'h43000000, 2'd0, 8'hF0, 8'h70, 1'b0});
    tbl.push_back('{32'hC3000000, 2'd0, 8'h00, 8'h80, 1'b0});
    tbl.push_back('{32'hC3010000, 2'd0, 8'h00, 8'h80, 1'b1});
    tbl.push_back('{32'h43FF8000, 2'd0, 8'h80, 8'h7F, 1'b1});
    tbl.push_back('{32'h44000000, 2'd0, 8'h80, 8'h7F, 1'b1});
    tbl.push_back('{32'hC4000000, 2'd0, 8'h7F, 8'h80, 1'b1});
    tbl.push_back('{32'h3F400000, 2'd3, 8'h00, 8'h00, 1'b0});
    tbl.push_back('{32'h3F400000, 2'd0, 8'h00, 8'h01, 1'b0});

    #1;
    check("reset q", q, 32'h0);
    check("reset q_valid", {31'h0, q_valid}, 32'h0);
    check("reset sat_cnt", {16'h0, sat_cnt}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // RNE back-to-back word
    lane_k(32'h40C00000, 2'd0, 8'h00, 1'b0, 8'h06, 1'b0);
    lane_k(32'hC0700000, 2'd0, 8'h00, 1'b0, 8'hFC, 1'b0);
    lane_k(32'h40200000, 2'd0, 8'h00, 1'b0, 8'h02, 1'b0);
    lane_k(32'h40600000, 2'd0, 8'h00, 1'b0, 8'h04, 1'b0);
    drain("rne");

    // toward zero
    lane_k(32'h40C00000, 2'd3, 8'h00, 1'b0, 8'h06, 1'b0);
    lane_k(32'hC0700000, 2'd3, 8'h00, 1'b0, 8'hFD, 1'b0);
    lane_k(32'h40200000, 2'd3, 8'h00, 1'b0, 8'h02, 1'b0);
    lane_k(32'h40600000, 2'd3, 8'h00, 1'b0, 8'h03, 1'b0);
    drain("rtz");

    // saturation and specials
    lane_k(32'h43960000, 2'd0, 8'h00, 1'b0, 8'h7F, 1'b1);
    lane_k(32'hFF800000, 2'd0, 8'h00, 1'b0, 8'h80, 1'b1);
    lane_k(32'h7FC12345, 2'd0, 8'h00, 1'b0, 8'h00, 1'b1);
    lane_k(32'h42FECCCD, 2'd0, 8'h00, 1'b0, 8'h7F, 1'b0);
    drain("specials");

    // zero point
    lane_k(32'h00000000, 2'd0, 8'h80, 1'b0, 8'h80, 1'b0);
    lane_k(32'h437F0000, 2'd0, 8'h80, 1'b0, 8'h7F, 1'b0);
    lane_k(32'h3F000000, 2'd0, 8'h80, 1'b0, 8'h80, 1'b0);
    lane_k(32'h43800000, 2'd0, 8'h80, 1'b0, 8'h7F, 1'b1);
    drain("zero point");

    // flush: partial word, empty clr, clr on word-completing lane
    lane_k(32'h3F800000, 2'd0, 8'h00, 1'b0, 8'h01, 1'b0);
    lane_k(32'hBF800000, 2'd0, 8'h00, 1'b0, 8'hFF, 1'b0);
    idle(1'b1);
    drain("flush partial");
    idle(1'b1);
    idle(1'b1);
    drain("flush empty");
    lane_k(32'h40000000, 2'd0, 8'h00, 1'b0, 8'h02, 1'b0);
    lane_k(32'h40400000, 2'd0, 8'h00, 1'b0, 8'h03, 1'b0);
    lane_k(32'h40800000, 2'd0, 8'h00, 1'b0, 8'h04, 1'b0);
    lane_k(32'h40A00000, 2'd0, 8'h00, 1'b1, 8'h05, 1'b0);
    drain("flush full");

    // single-lane words from the vector table
    foreach (tbl[i]) lane_k(tbl[i].a, tbl[i].rm, tbl[i].zp, 1'b1, tbl[i].y, tbl[i].sat);
    drain("table");

    // randomized lanes, duty cycle and flushes
    for (int i = 0; i < 400; i++) begin
      logic [31:0] av;
      logic        sg;
      sg = 1'($urandom);
      case ($urandom_range(0, 7))
        0: av = {sg, 8'h00, 23'($urandom)};
        1: av = {sg, 31'h0};
        2: av = {sg, 8'hFF, 23'h0};
        3: av = {sg, 8'hFF, 22'($urandom), 1'b1};
        default: av = {sg, 8'($urandom_range(110, 137)), 23'($urandom)};
      endcase
      if ($urandom_range(0, 3) != 0)
        lane_r(av, 2'($urandom), 8'($urandom), $urandom_range(0, 11) == 0);
      else
        idle($urandom_range(0, 5) == 0);
    end
    idle(1'b1);
    drain("random");

    // reset in the middle of a word
    lane_k(32'h3F800000, 2'd0, 8'h00, 1'b0, 8'h01, 1'b0);
    lane_k(32'hBF800000, 2'd0, 8'h00, 1'b0, 8'hFF, 1'b0);
    @(negedge clk);
    ena = 1'b0;
    rstn = 1'b0;
    part.delete();
    exp_sat = 0;
    #1;
    check("midreset q", q, 32'h0);
    check("midreset q_valid", {31'h0, q_valid}, 32'h0);
    check("midreset sat_cnt", {16'h0, sat_cnt}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    lane_k(32'h40000000, 2'd0, 8'h00, 1'b0, 8'h02, 1'b0);
    lane_k(32'h40400000, 2'd0, 8'h00, 1'b0, 8'h03, 1'b0);
    lane_k(32'h43960000, 2'd0, 8'h00, 1'b0, 8'h7F, 1'b1);
    lane_k(32'hC0000000, 2'd0, 8'h00, 1'b0, 8'hFE, 1'b0);
    drain("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
